// File: rtl/mc_axi_init.sv
// mc_axi_init: AXI burst initiator turning a one-at-a-time command plus write/read streams into AXI bursts.
// Latency: cmd handshake N -> legality check N+1 -> AW/AR valid N+2; illegal done N+2; single-beat write done N+5.
// Backpressure: cmd_ready only in IDLE; W/R beats pass combinationally between stream and AXI ports, so each side stalls the other.
//
// Ports: zmc_top_clk/zmc_top_rst (async active-high), cmd_* (command in), wd_* (write stream in),
//        rd_* (read stream out), done_* (completion pulse), aw*/w*/b*/ar*/r* (AXI manager), timeout_err (sticky).
// Optional feature: define MC_AXI_INIT_TIMEOUT_EN to abort a stalled burst after TIMEOUT_CYCLES idle cycles.
module mc_axi_init #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        zmc_top_clk,
   input  logic        zmc_top_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [3:0]  cmd_len,
   input  logic [1:0]  cmd_burst,
   input  logic        wd_valid,
   output logic        wd_ready,
   input  logic [31:0] wd_data,
   input  logic [3:0]  wd_strb,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [31:0] rd_data,
   output logic        rd_last,
   output logic [1:0]  rd_resp,
   output logic        done_valid,
   output logic [1:0]  done_resp,
   output logic        done_wr,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   input  logic [1:0]  bresp,
   output logic        bready,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        timeout_err
);

   typedef enum logic [2:0] {IDLE, CHK, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

   state_t      state_q;
   logic        cmd_ready_q, wr_q, wlast_q, awvalid_q, arvalid_q, bready_q;
   logic [31:0] addr_q;
   logic [3:0]  len_q, beat_q;
   logic [1:0]  burst_q, rresp_q, rresp_d;
   logic        rerr_q, rerr_d;
   logic        done_valid_q, done_wr_q;
   logic [1:0]  done_resp_q;
   logic [13:0] incr_end;
   logic        legal, abort;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

   // Combinational pass-through of the data streams, gated by the owning state.
   assign wvalid   = (state_q == WR_DATA) & wd_valid;
   assign wd_ready = (state_q == WR_DATA) & wready;
   assign wdata    = wd_data;
   assign wstrb    = wd_strb;
   assign rd_valid = (state_q == RD_DATA) & rvalid;
   assign rready   = (state_q == RD_DATA) & rd_ready;
   assign rd_data  = rdata;
   assign rd_resp  = rresp;
   assign rd_last  = (state_q == RD_DATA) & rlast;

   assign cmd_ready  = cmd_ready_q;
   assign awaddr     = addr_q;
   assign awlen      = len_q;
   assign awburst    = burst_q;
   assign awvalid    = awvalid_q;
   assign araddr     = addr_q;
   assign arlen      = len_q;
   assign arburst    = burst_q;
   assign arvalid    = arvalid_q;
   assign wlast      = wlast_q;
   assign bready     = bready_q;
   assign done_valid = done_valid_q;
   assign done_resp  = done_resp_q;
   assign done_wr    = done_wr_q;

   assign aw_hs = awvalid_q & awready;
   assign w_hs  = wvalid & wready;
   assign b_hs  = bready_q & bvalid;
   assign ar_hs = arvalid_q & arready;
   assign r_hs  = rvalid & rready;

   // End byte offset of an INCR burst within its 4 KB page; 4096 exactly is still legal.
   assign incr_end = {2'b00, addr_q[11:0]} + {7'd0, {1'b0, len_q} + 5'd1, 2'b00};

   always_comb begin
      legal = 1'b1;
      if (burst_q == 2'b11) legal = 1'b0;
      if (burst_q == 2'b10 && !(len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15))
         legal = 1'b0;
      if (burst_q != 2'b00 && addr_q[1:0] != 2'b00) legal = 1'b0;
      if (burst_q == 2'b01 && incr_end > 14'd4096) legal = 1'b0;
   end

   // Worst-case read response and protocol error, folded in on each accepted beat.
   // An rlast that disagrees with the expected last beat is a protocol error.
   always_comb begin
      rresp_d = (rresp > rresp_q) ? rresp : rresp_q;
      rerr_d  = rerr_q | (rlast != (beat_q == len_q));
   end

`ifdef MC_AXI_INIT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_err_q, waiting, any_hs;

   assign waiting = (state_q == WR_ADDR) | (state_q == WR_DATA) | (state_q == WR_RESP) |
                    (state_q == RD_ADDR) | (state_q == RD_DATA);
   assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
   // Every state change coincides with a handshake or a non-waiting state, so this also restarts per state.
   assign abort   = waiting & ~any_hs & (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = tmo_err_q;

   always_ff @(posedge zmc_top_clk or posedge zmc_top_rst) begin
      if (zmc_top_rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         if (!waiting || any_hs || abort) tmo_cnt_q <= '0;
         else                             tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         if (abort) tmo_err_q <= 1'b1;
      end
   end
`else
   logic [31:0] tmo_unused;
   assign tmo_unused  = 32'(TIMEOUT_CYCLES);
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge zmc_top_clk or posedge zmc_top_rst) begin
      if (zmc_top_rst) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         len_q        <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         wlast_q      <= 1'b0;
         awvalid_q    <= 1'b0;
         arvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         rresp_q      <= '0;
         rerr_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_resp_q  <= '0;
         done_wr_q    <= 1'b0;
      end else begin
         done_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  wr_q        <= cmd_wr;
                  addr_q      <= cmd_addr;
                  len_q       <= cmd_len;
                  burst_q     <= cmd_burst;
                  state_q     <= CHK;
               end
            end
            CHK: begin
               if (!legal) begin
                  done_valid_q <= 1'b1;
                  done_resp_q  <= 2'b10;
                  done_wr_q    <= wr_q;
                  state_q      <= DONE;
               end else if (wr_q) begin
                  awvalid_q <= 1'b1;
                  state_q   <= WR_ADDR;
               end else begin
                  arvalid_q <= 1'b1;
                  state_q   <= RD_ADDR;
               end
            end
            WR_ADDR: if (aw_hs) begin
               awvalid_q <= 1'b0;
               beat_q    <= '0;
               wlast_q   <= (len_q == 4'd0);
               state_q   <= WR_DATA;
            end
            WR_DATA: if (w_hs) begin
               if (beat_q == len_q) begin
                  wlast_q  <= 1'b0;
                  bready_q <= 1'b1;
                  state_q  <= WR_RESP;
               end else begin
                  beat_q  <= beat_q + 4'd1;
                  wlast_q <= ((beat_q + 4'd1) == len_q);
               end
            end
            WR_RESP: if (b_hs) begin
               bready_q     <= 1'b0;
               done_valid_q <= 1'b1;
               done_resp_q  <= bresp;
               done_wr_q    <= 1'b1;
               state_q      <= DONE;
            end
            RD_ADDR: if (ar_hs) begin
               arvalid_q <= 1'b0;
               beat_q    <= '0;
               rresp_q   <= '0;
               rerr_q    <= 1'b0;
               state_q   <= RD_DATA;
            end
            RD_DATA: if (r_hs) begin
               rresp_q <= rresp_d;
               rerr_q  <= rerr_d;
               beat_q  <= beat_q + 4'd1;
               // Beats past a bad count are drained; only rlast ends the burst.
               if (rlast) begin
                  done_valid_q <= 1'b1;
                  done_resp_q  <= rerr_d ? 2'b10 : rresp_d;
                  done_wr_q    <= 1'b0;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // A timeout abort only fires when no handshake happens, so it cannot clash with the moves above.
         if (abort) begin
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            wlast_q      <= 1'b0;
            done_valid_q <= 1'b1;
            done_resp_q  <= 2'b11;
            done_wr_q    <= wr_q;
            state_q      <= DONE;
         end
      end
   end

endmodule
